// File: rtl/tri_draw_sequencer_pkg.sv
// Shared definitions for the triangle draw sequencer: FSM encoding, default widths
// and the packed vertex layout {x, y}.
package tri_draw_sequencer_pkg;

  localparam int DEF_VERTEX_DATA_WIDTH = 32;
  localparam int DEF_PIXEL_ADDR_WIDTH  = 16;
  localparam int DEF_COLOR_WIDTH       = 16;
  localparam int DEF_FIFO_DEPTH        = 4;
  localparam int DEF_WDOG_CYCLES       = 1024;

  // Packed vertex fields: x in the upper half, y in the lower half.
  localparam int VTX_FIELD_W = 16;
  localparam int VTX_X_LSB   = 16;
  localparam int VTX_Y_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_ACK    = 3'd3,
    ST_SETTLE = 3'd4
  } seq_state_e;

  function automatic logic [DEF_VERTEX_DATA_WIDTH-1:0] vtx_pack(
    input logic [VTX_FIELD_W-1:0] x,
    input logic [VTX_FIELD_W-1:0] y
  );
    logic [DEF_VERTEX_DATA_WIDTH-1:0] v;
    v = '0;
    v[VTX_X_LSB +: VTX_FIELD_W] = x;
    v[VTX_Y_LSB +: VTX_FIELD_W] = y;
    return v;
  endfunction

endpackage

// File: rtl/tri_draw_sequencer_cmd_fifo.sv
// Command queue: power-of-two depth, wrap-bit pointers, first-word-fall-through read.
module cmd_fifo
  import tri_draw_sequencer_pkg::*;
#(
  parameter int WIDTH = 3 * DEF_VERTEX_DATA_WIDTH + DEF_COLOR_WIDTH,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tri_draw_sequencer.sv
// Sequences queued triangle draw commands into an external filler and forwards its
// pixels to a sink, with a watchdog guarding against a stalled filler.
module tri_draw_sequencer
  import tri_draw_sequencer_pkg::*;
#(
  parameter int VERTEX_DATA_WIDTH = DEF_VERTEX_DATA_WIDTH,
  parameter int PIXEL_ADDR_WIDTH  = DEF_PIXEL_ADDR_WIDTH,
  parameter int COLOR_WIDTH       = DEF_COLOR_WIDTH,
  parameter int FIFO_DEPTH        = DEF_FIFO_DEPTH,
  parameter int WDOG_CYCLES       = DEF_WDOG_CYCLES
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [VERTEX_DATA_WIDTH-1:0]  cmd_v0,
  input  logic [VERTEX_DATA_WIDTH-1:0]  cmd_v1,
  input  logic [VERTEX_DATA_WIDTH-1:0]  cmd_v2,
  input  logic [COLOR_WIDTH-1:0]        cmd_color,
  output logic                          fill_start,
  output logic [VERTEX_DATA_WIDTH-1:0]  fill_v0,
  output logic [VERTEX_DATA_WIDTH-1:0]  fill_v1,
  output logic [VERTEX_DATA_WIDTH-1:0]  fill_v2,
  input  logic [PIXEL_ADDR_WIDTH-1:0]   fill_x,
  input  logic [PIXEL_ADDR_WIDTH-1:0]   fill_y,
  input  logic                          fill_valid,
  output logic                          fill_ready,
  input  logic                          fill_done,
  output logic [PIXEL_ADDR_WIDTH-1:0]   pix_x,
  output logic [PIXEL_ADDR_WIDTH-1:0]   pix_y,
  output logic [COLOR_WIDTH-1:0]        pix_color,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic                          busy,
  output logic                          err,
  input  logic                          err_clr,
  output logic [2*PIXEL_ADDR_WIDTH-1:0] pix_count
);

  localparam int CMD_W = 3 * VERTEX_DATA_WIDTH + COLOR_WIDTH;
  localparam int CNT_W = 2 * PIXEL_ADDR_WIDTH;
  localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

  seq_state_e                   state_q;
  logic                         fill_start_q;
  logic                         err_q;
  logic                         err_d;
  logic [VERTEX_DATA_WIDTH-1:0] v0_q;
  logic [VERTEX_DATA_WIDTH-1:0] v1_q;
  logic [VERTEX_DATA_WIDTH-1:0] v2_q;
  logic [COLOR_WIDTH-1:0]       color_q;
  logic [CNT_W-1:0]             pix_count_q;
  logic [CNT_W-1:0]             pix_count_d;
  logic [WD_W-1:0]              wdog_q;
  logic [WD_W-1:0]              wdog_d;

  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_pop;
  logic [CMD_W-1:0]             fifo_wdata;
  logic [CMD_W-1:0]             fifo_rdata;
  logic [VERTEX_DATA_WIDTH-1:0] head_v0;
  logic [VERTEX_DATA_WIDTH-1:0] head_v1;
  logic [VERTEX_DATA_WIDTH-1:0] head_v2;
  logic [COLOR_WIDTH-1:0]       head_color;

  logic                         in_run;
  logic                         pix_hs;
  logic                         wdog_idle;
  logic                         wdog_expire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign fifo_wdata = {cmd_v0, cmd_v1, cmd_v2, cmd_color};
  assign {head_v0, head_v1, head_v2, head_color} = fifo_rdata;
  assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty;

  cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (cmd_valid),
    .pop_i   (fifo_pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Pixel path is purely combinational; only RUN lets pixels through.
  assign in_run     = (state_q == ST_RUN);
  assign pix_x      = fill_x;
  assign pix_y      = fill_y;
  assign pix_valid  = fill_valid && in_run;
  assign fill_ready = pix_ready;
  assign pix_color  = color_q;
  assign pix_hs     = pix_valid && pix_ready;

  // Only a silent filler ages the watchdog; a stalled sink never does.
  assign wdog_idle   = in_run && !fill_valid && !fill_done;
  assign wdog_expire = wdog_idle && (wdog_q == WD_W'(WDOG_CYCLES - 1));

  always_comb begin
    err_d       = err_q;
    pix_count_d = pix_count_q;
    wdog_d      = wdog_q;
    if (wdog_expire) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
    if (state_q == ST_ISSUE) begin
      pix_count_d = '0;
      wdog_d      = '0;
    end else begin
      if (pix_hs) pix_count_d = sat_inc(pix_count_q);
      if (in_run && fill_valid) begin
        wdog_d = '0;
      end else if (wdog_idle) begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      fill_start_q <= 1'b0;
      err_q        <= 1'b0;
      pix_count_q  <= '0;
      wdog_q       <= '0;
      v0_q         <= '0;
      v1_q         <= '0;
      v2_q         <= '0;
      color_q      <= '0;
    end else begin
      err_q        <= err_d;
      pix_count_q  <= pix_count_d;
      wdog_q       <= wdog_d;
      fill_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            v0_q         <= head_v0;
            v1_q         <= head_v1;
            v2_q         <= head_v2;
            color_q      <= head_color;
            fill_start_q <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_RUN;
        ST_RUN: begin
          if (fill_done || wdog_expire) begin
            fill_start_q <= 1'b1;
            state_q      <= ST_ACK;
          end
        end
        ST_ACK: state_q <= ST_SETTLE;
        ST_SETTLE: begin
          if (!fill_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign fill_start = fill_start_q;
  assign fill_v0    = v0_q;
  assign fill_v1    = v1_q;
  assign fill_v2    = v2_q;
  assign err        = err_q;
  assign pix_count  = pix_count_q;
  assign cmd_ready  = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_tri_draw_sequencer.sv
// Bench for tri_draw_sequencer: behavioural filler, command-level scoreboard and
// directed scenarios for latency, backpressure, queue full, watchdog and reset.
module tb_tri_draw_sequencer;
  import tri_draw_sequencer_pkg::*;

  localparam int VW = 32;
  localparam int PW = 16;
  localparam int CW = 16;

  typedef struct {
    logic [VW-1:0] v0;
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
    logic [CW-1:0] col;
    int            npix;   // negative: filler stays silent forever
    int            tag;
  } cmd_t;

  logic            clk;
  logic            resetn;
  logic            cmd_valid;
  logic            cmd_ready;
  logic [VW-1:0]   cmd_v0, cmd_v1, cmd_v2;
  logic [CW-1:0]   cmd_color;
  logic            fill_start;
  logic [VW-1:0]   fill_v0, fill_v1, fill_v2;
  logic [PW-1:0]   fill_x, fill_y;
  logic            fill_valid, fill_ready, fill_done;
  logic [PW-1:0]   pix_x, pix_y;
  logic [CW-1:0]   pix_color;
  logic            pix_valid, pix_ready;
  logic            busy, err, err_clr;
  logic [2*PW-1:0] pix_count;

  int   stim_npix, stim_tag;
  int   n_vec, n_bad;
  int   n_issue, n_ack, n_hs;
  cmd_t exp_q[$];
  cmd_t fq[$];
  cmd_t cur;
  bit   in_cmd, prev_fs, err_m;
  int   cur_idx, cyc;

  tri_draw_sequencer #(
    .VERTEX_DATA_WIDTH (VW),
    .PIXEL_ADDR_WIDTH  (PW),
    .COLOR_WIDTH       (CW),
    .FIFO_DEPTH        (4),
    .WDOG_CYCLES       (1024)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_v0     (cmd_v0),
    .cmd_v1     (cmd_v1),
    .cmd_v2     (cmd_v2),
    .cmd_color  (cmd_color),
    .fill_start (fill_start),
    .fill_v0    (fill_v0),
    .fill_v1    (fill_v1),
    .fill_v2    (fill_v2),
    .fill_x     (fill_x),
    .fill_y     (fill_y),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_done  (fill_done),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_color  (pix_color),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr),
    .pix_count  (pix_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Behavioural filler: on a start pulse it emits npix pixels (x=index, y=tag),
  // then holds done until the next start pulse returns it to idle.
  initial begin : filler
    int   ph;
    int   idx;
    cmd_t fc;
    bit   st, hs;
    ph = 0; idx = 0;
    fc = '{default: 0};
    fill_valid = 1'b0; fill_done = 1'b0; fill_x = '0; fill_y = '0;
    forever begin
      @(negedge clk);
      st = fill_start;
      hs = fill_valid && fill_ready;
      if (resetn) begin
        case (ph)
          0: if (st) begin
               if (fq.size() > 0) fc = fq.pop_front();
               idx = 0;
               ph  = (fc.npix == 0) ? 2 : 1;
             end
          1: if (fc.npix < 0) begin
               if (st) ph = 0;
             end else if (hs) begin
               idx++;
               if (idx >= fc.npix) ph = 2;
             end
          default: if (st) ph = 0;
        endcase
      end
      @(posedge clk);
      #1;
      if (!resetn) begin
        ph = 0;
        idx = 0;
      end
      fill_valid = (ph == 1) && (fc.npix > 0);
      fill_done  = (ph == 2);
      fill_x     = PW'(idx);
      fill_y     = PW'(fc.tag);
    end
  end

  // Command-level model: commands leave in push order; each start-pulse pair
  // brackets one command whose pixels, colour and vertices are checked.
  always @(negedge clk) begin : scoreboard
    bit   ack;
    cmd_t c;
    ack = 1'b0;
    if (!resetn) begin
      exp_q.delete();
      fq.delete();
      in_cmd = 1'b0; prev_fs = 1'b0; err_m = 1'b0; cur_idx = 0; cyc = 0;
    end else begin
      check("fill_start_back_to_back", 64'(prev_fs && fill_start), 64'(0));
      if (fill_start && !in_cmd) begin
        n_issue++;
        if (exp_q.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL issue_without_cmd: actual=start pulse required=no pulse (queue empty)");
        end else begin
          cur = exp_q.pop_front();
          in_cmd = 1'b1; cur_idx = 0; cyc = 0;
        end
      end else if (fill_start && in_cmd) begin
        n_ack++;
        ack = 1'b1;
        if (cur.npix < 0) begin
          check("wdog_span", 64'(cyc), 64'(1025));
          check("wdog_pix_count", 64'(pix_count), 64'(0));
          err_m = 1'b1;
        end else begin
          check("ack_pixels", 64'(cur_idx), 64'(cur.npix));
          check("ack_pix_count", 64'(pix_count), 64'(cur.npix));
        end
      end
      if (in_cmd) begin
        check("fill_v0", 64'(fill_v0), 64'(cur.v0));
        check("fill_v1", 64'(fill_v1), 64'(cur.v1));
        check("fill_v2", 64'(fill_v2), 64'(cur.v2));
        check("pix_color", 64'(pix_color), 64'(cur.col));
        if (pix_valid && pix_ready) begin
          check("pix_x_order", 64'(pix_x), 64'(cur_idx));
          check("pix_y_tag", 64'(pix_y), 64'(cur.tag));
          cur_idx++;
          n_hs++;
        end
      end
      check("pix_valid", 64'(pix_valid), 64'(fill_valid && in_cmd && !fill_start));
      check("pix_xy_pass", 64'({pix_x, pix_y}), 64'({fill_x, fill_y}));
      check("err", 64'(err), 64'(err_m));
      if (err_clr) err_m = 1'b0;
      if (ack) in_cmd = 1'b0;
      cyc++;
      prev_fs = fill_start;
      if (cmd_valid && cmd_ready) begin
        c.v0 = cmd_v0; c.v1 = cmd_v1; c.v2 = cmd_v2; c.col = cmd_color;
        c.npix = stim_npix; c.tag = stim_tag;
        exp_q.push_back(c);
        fq.push_back(c);
      end
    end
  end

  task automatic push_cmd(input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input logic [VW-1:0] c, input logic [CW-1:0] col,
                          input int np, input int tag);
    int   k;
    logic acc;
    cmd_v0 = a; cmd_v1 = b; cmd_v2 = c; cmd_color = col;
    stim_npix = np; stim_tag = tag;
    cmd_valid = 1'b1;
    acc = 1'b0; k = 0;
    while (!acc && k < 100) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      k++;
    end
    cmd_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL push_timeout: actual=not accepted required=accepted (tag %0d)", tag);
    end
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      cycles(1);
      k++;
    end
    check(nm, 64'(busy), 64'(0));
  endtask

  initial begin : main
    int   i0, a0, h0, k;
    logic r;
    n_vec = 0; n_bad = 0; n_issue = 0; n_ack = 0; n_hs = 0;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_v0 = '0; cmd_v1 = '0; cmd_v2 = '0;
    cmd_color = '0; pix_ready = 1'b1; err_clr = 1'b0; stim_npix = 0; stim_tag = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_fill_start", 64'(fill_start), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_pix_count", 64'(pix_count), 64'(0));
    check("rst_fill_v0", 64'(fill_v0), 64'(0));
    resetn = 1'b1;
    cycles(2);

    // Single command, 15 pixels, start pulse one cycle after the push edge.
    i0 = n_issue; a0 = n_ack; h0 = n_hs;
    push_cmd(32'h0000_0000, 32'h0004_0000, 32'h0000_0004, 16'hF800, 15, 1);
    check("lat_still_idle", 64'(fill_start), 64'(0));
    check("lat_busy", 64'(busy), 64'(1));
    cycles(1);
    check("lat_issue_pulse", 64'(fill_start), 64'(1));
    check("lat_fill_v1", 64'(fill_v1), 64'h0004_0000);
    check("lat_color", 64'(pix_color), 64'hF800);
    cycles(1);
    check("lat_pulse_one_cycle", 64'(fill_start), 64'(0));
    wait_idle(200, "single_idle");
    check("single_pix_count", 64'(pix_count), 64'(15));
    check("single_pulses", 64'((n_issue - i0) + (n_ack - a0)), 64'(2));
    check("single_pixels", 64'(n_hs - h0), 64'(15));

    // Sink stalled for 2000 cycles while the filler holds a pixel.
    h0 = n_hs;
    pix_ready = 1'b0;
    push_cmd(vtx_pack(16'd1, 16'd1), vtx_pack(16'd9, 16'd1), vtx_pack(16'd1, 16'd9),
             16'h07E0, 8, 2);
    k = 0;
    while (!pix_valid && k < 50) begin
      cycles(1);
      k++;
    end
    check("bp_valid_seen", 64'(pix_valid), 64'(1));
    cycles(2000);
    check("bp_err_clear", 64'(err), 64'(0));
    check("bp_no_pixels", 64'(pix_count), 64'(0));
    pix_ready = 1'b1;
    wait_idle(200, "bp_idle");
    check("bp_pix_count", 64'(pix_count), 64'(8));
    check("bp_pixels", 64'(n_hs - h0), 64'(8));

    // Queue fills during a long draw: four accepted, then cmd_ready low.
    i0 = n_issue; h0 = n_hs;
    push_cmd(vtx_pack(16'd0, 16'd0), vtx_pack(16'd40, 16'd0), vtx_pack(16'd0, 16'd40),
             16'h001F, 40, 3);
    cycles(2);
    for (int q = 0; q < 6; q++) begin
      cmd_v0 = vtx_pack(16'(q), 16'(q + 1));
      cmd_v1 = vtx_pack(16'(q + 2), 16'(q));
      cmd_v2 = vtx_pack(16'(q), 16'(q + 3));
      cmd_color = 16'h1000 + 16'(q);
      stim_npix = 3; stim_tag = 10 + q;
      cmd_valid = 1'b1;
      @(negedge clk);
      r = cmd_ready;
      check("qfull_ready", 64'(r), 64'(q < 4));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    wait_idle(1000, "qfull_idle");
    check("qfull_issues", 64'(n_issue - i0), 64'(5));
    check("qfull_pixels", 64'(n_hs - h0), 64'(52));

    // Silent filler trips the watchdog; the next queued command still runs.
    i0 = n_issue; a0 = n_ack; h0 = n_hs;
    push_cmd(vtx_pack(16'd2, 16'd2), vtx_pack(16'd3, 16'd3), vtx_pack(16'd4, 16'd2),
             16'hAAAA, -1, 20);
    push_cmd(vtx_pack(16'd5, 16'd5), vtx_pack(16'd6, 16'd5), vtx_pack(16'd5, 16'd6),
             16'h5555, 2, 21);
    check("wdog_err_not_yet", 64'(err), 64'(0));
    wait_idle(3000, "wdog_idle");
    check("wdog_err_set", 64'(err), 64'(1));
    check("wdog_issues", 64'(n_issue - i0), 64'(2));
    check("wdog_acks", 64'(n_ack - a0), 64'(2));
    check("wdog_next_pixels", 64'(n_hs - h0), 64'(2));
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("wdog_err_cleared", 64'(err), 64'(0));

    // Reset in RUN after five pixels with a second command queued.
    h0 = n_hs;
    push_cmd(vtx_pack(16'd7, 16'd7), vtx_pack(16'd27, 16'd7), vtx_pack(16'd7, 16'd27),
             16'h0F0F, 20, 30);
    push_cmd(vtx_pack(16'd8, 16'd8), vtx_pack(16'd9, 16'd8), vtx_pack(16'd8, 16'd9),
             16'hF0F0, 3, 31);
    k = 0;
    while ((n_hs - h0) < 5 && k < 100) begin
      cycles(1);
      k++;
    end
    check("rst_mid_pixels", 64'(n_hs - h0), 64'(5));
    #1;
    resetn = 1'b0;
    i0 = n_issue;
    #1;
    check("mid_rst_fill_start", 64'(fill_start), 64'(0));
    check("mid_rst_pix_count", 64'(pix_count), 64'(0));
    check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_pix_valid", 64'(pix_valid), 64'(0));
    check("mid_rst_err", 64'(err), 64'(0));
    check("mid_rst_vertices", 64'(fill_v0 | fill_v1 | fill_v2), 64'(0));
    check("mid_rst_color", 64'(pix_color), 64'(0));
    cycles(2);
    resetn = 1'b1;
    cycles(30);
    check("post_rst_no_issue", 64'(n_issue - i0), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_fill_start", 64'(fill_start), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
